// File: rtl/password_entry.sv
// Collects a user index plus four digits, presents the word for one cycle, then waits for a grant with timeout and lockout.
// Outputs are registered or decoded from state; Fail follows _Access_Grant combinationally; there is no backpressure (the load is a single pulse).
module password_entry #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int GRANT_WAIT     = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  _Digit_In,
    input  logic        _Digit_Load,
    input  logic [1:0]  _User_Sel,
    input  logic        _Logout,
    input  logic        _Access_Grant,
    output logic [17:0] Data_Out,
    output logic        Data_Out_Load,
    output logic [2:0]  Digit_Count,
    output logic        Logged_In,
    output logic        Locked,
    output logic        Fail
);

    localparam int WW = (GRANT_WAIT > 1) ? $clog2(GRANT_WAIT) : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int FW = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [WW-1:0] WAIT_LAST = WW'(GRANT_WAIT - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SEND,
        WAIT_RESP,
        GRANTED,
        LOCKED
    } state_t;

    state_t         state, state_nx;
    logic [17:0]    data_q, data_nx;
    logic [2:0]     count_q, count_nx;
    logic [WW-1:0]  wait_q, wait_nx;
    logic [LW-1:0]  lock_q, lock_nx;
    logic [FW-1:0]  fails_q, fails_nx;
    logic [FW-1:0]  fails_inc;
    logic           fail_pulse;

    assign fails_inc = fails_q + FW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
            lock_q  <= '0;
            fails_q <= '0;
        end else begin
            state   <= state_nx;
            data_q  <= data_nx;
            count_q <= count_nx;
            wait_q  <= wait_nx;
            lock_q  <= lock_nx;
            fails_q <= fails_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        data_nx    = data_q;
        count_nx   = count_q;
        wait_nx    = wait_q;
        lock_nx    = lock_q;
        fails_nx   = fails_q;
        fail_pulse = 1'b0;

        case (state)
            IDLE: begin
                // Logout dominates a coincident digit, here as in COLLECT.
                if (!_Logout && _Digit_Load) begin
                    data_nx  = {_User_Sel, 12'h000, _Digit_In};
                    count_nx = 3'd1;
                    state_nx = COLLECT;
                end
            end

            COLLECT: begin
                if (_Logout) begin
                    data_nx  = '0;
                    count_nx = '0;
                    state_nx = IDLE;
                end else if (_Digit_Load) begin
                    data_nx[15:0] = {data_q[11:0], _Digit_In};
                    count_nx      = count_q + 3'd1;
                    if (count_q == 3'd3) begin
                        state_nx = SEND;
                    end
                end
            end

            SEND: begin
                count_nx = '0;
                wait_nx  = '0;
                state_nx = WAIT_RESP;
            end

            WAIT_RESP: begin
                if (_Access_Grant) begin
                    fails_nx = '0;
                    state_nx = GRANTED;
                end else if (wait_q == WAIT_LAST) begin
                    fail_pulse = 1'b1;
                    fails_nx   = fails_inc;
                    data_nx    = '0;
                    lock_nx    = '0;
                    state_nx   = (fails_inc == FAIL_MAX) ? LOCKED : IDLE;
                end else begin
                    wait_nx = wait_q + WW'(1);
                end
            end

            GRANTED: begin
                // Grant was high on entry, so a low level here is a fall.
                if (_Logout || !_Access_Grant) begin
                    data_nx  = '0;
                    state_nx = IDLE;
                end
            end

            LOCKED: begin
                if (lock_q == LOCK_LAST) begin
                    fails_nx = '0;
                    state_nx = IDLE;
                end else begin
                    lock_nx = lock_q + LW'(1);
                end
            end

            default: begin
                data_nx  = '0;
                count_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign Data_Out      = data_q;
    assign Digit_Count   = count_q;
    assign Data_Out_Load = (state == SEND);
    assign Logged_In     = (state == GRANTED);
    assign Locked        = (state == LOCKED);
    assign Fail          = fail_pulse;

endmodule

// File: tb/tb_password_entry.sv
// Randomised and directed bench for password_entry against a queue-based behavioural model.
module tb_password_entry;

    localparam int MAXA  = 3;
    localparam int GW    = 8;
    localparam int LOCKC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit_in;
    logic        digit_load;
    logic [1:0]  user_sel;
    logic        logout;
    logic        grant;
    logic [17:0] data_out;
    logic        data_load;
    logic [2:0]  digit_count;
    logic        logged_in;
    logic        locked;
    logic        fail;

    int checks = 0;
    int errors = 0;

    // Behavioural model: queued digits plus a few mode flags and countdowns.
    int digits[$];
    int m_user;
    bit m_send, m_wait, m_sess;
    int m_waited, m_lock, m_fails;

    // Last sampled DUT outputs, used by the directed literal checks.
    logic [17:0] s_data;
    logic        s_load, s_logged, s_locked, s_fail;
    logic [2:0]  s_count;

    password_entry #(
        .MAX_ATTEMPTS(MAXA),
        .GRANT_WAIT(GW),
        .LOCKOUT_CYCLES(LOCKC)
    ) dut (
        .clk(clk),
        .rst(rst),
        ._Digit_In(digit_in),
        ._Digit_Load(digit_load),
        ._User_Sel(user_sel),
        ._Logout(logout),
        ._Access_Grant(grant),
        .Data_Out(data_out),
        .Data_Out_Load(data_load),
        .Digit_Count(digit_count),
        .Logged_In(logged_in),
        .Locked(locked),
        .Fail(fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] model_word();
        int w;
        logic [1:0] u;
        w = 0;
        foreach (digits[i]) w = ((w << 4) | digits[i]) & 16'hFFFF;
        u = m_user[1:0];
        return {u, w[15:0]};
    endfunction

    task automatic model_reset();
        digits.delete();
        m_user = 0; m_send = 0; m_wait = 0; m_sess = 0;
        m_waited = 0; m_lock = 0; m_fails = 0;
    endtask

    task automatic model_update(input bit ld, input int d, input int u, input bit lo, input bit g);
        if (m_sess) begin
            if (lo || !g) begin
                m_sess = 0;
                digits.delete();
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_wait) begin
            if (g) begin
                m_wait = 0; m_sess = 1; m_fails = 0;
            end else if (m_waited == GW - 1) begin
                m_wait = 0;
                digits.delete();
                m_fails++;
                if (m_fails == MAXA) m_lock = LOCKC;
            end else begin
                m_waited++;
            end
        end else if (m_send) begin
            m_send = 0; m_wait = 1; m_waited = 0;
        end else if (lo) begin
            digits.delete();
        end else if (ld) begin
            if (digits.size() == 0) m_user = u;
            digits.push_back(d);
            if (digits.size() == 4) m_send = 1;
        end
    endtask

    // One clock cycle: drive at negedge, compare shortly after, advance model at posedge.
    task automatic step(input bit ld, input int d, input int u, input bit lo, input bit g);
        logic [17:0] e_data;
        int e_count;
        @(negedge clk);
        digit_load = ld;
        digit_in   = d[3:0];
        user_sel   = u[1:0];
        logout     = lo;
        grant      = g;
        #1;
        e_data  = (digits.size() > 0) ? model_word() : 18'h0;
        e_count = m_send ? 4 : ((m_wait || m_sess) ? 0 : digits.size());
        chk("data_out",    32'(data_out),    32'(e_data));
        chk("data_load",   32'(data_load),   32'(m_send));
        chk("digit_count", 32'(digit_count), 32'(e_count));
        chk("logged_in",   32'(logged_in),   32'(m_sess));
        chk("locked",      32'(locked),      32'(m_lock > 0));
        chk("fail",        32'(fail),        32'(m_wait && (m_waited == GW - 1) && !g));
        s_data = data_out; s_load = data_load; s_count = digit_count;
        s_logged = logged_in; s_locked = locked; s_fail = fail;
        @(posedge clk);
        model_update(ld, d, u, lo, g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        digit_load = 1'b0; logout = 1'b0; grant = 1'b0;
        #1;
        chk("rst_data",   32'(data_out),    32'h0);
        chk("rst_load",   32'(data_load),   32'h0);
        chk("rst_count",  32'(digit_count), 32'h0);
        chk("rst_logged", 32'(logged_in),   32'h0);
        chk("rst_locked", 32'(locked),      32'h0);
        chk("rst_fail",   32'(fail),        32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic enter(input int u, input int a, input int b, input int c, input int e);
        step(1, a, u, 0, 0);
        step(1, b, u, 0, 0);
        step(1, c, u, 0, 0);
        step(1, e, u, 0, 0);
    endtask

    // Entry followed by a full ungranted wait; returns the cycle offsets seen.
    task automatic fail_entry(output int load_at, output int fail_at);
        load_at = -1;
        fail_at = -1;
        enter(1, 4, 4, 4, 4);
        for (int i = 0; i <= GW; i++) begin
            step(0, 0, 0, 0, 0);
            if (s_load) load_at = i;
            if (s_fail) fail_at = i;
        end
    endtask

    initial begin
        int la, fa, nlock, maxcnt, nload;
        bit g;
        rst = 1'b1;
        digit_in = '0; digit_load = 1'b0; user_sel = '0; logout = 1'b0; grant = 1'b0;
        model_reset();
        #3 rst = 1'b0;
        #1;
        chk("init_data",   32'(data_out),    32'h0);
        chk("init_count",  32'(digit_count), 32'h0);
        chk("init_locked", 32'(locked),      32'h0);
        @(negedge clk);
        rst = 1'b1;

        // User 2 enters 1,2,3,4; grant rises three cycles after the load.
        step(1, 1, 2, 0, 0);
        step(1, 2, 2, 0, 0); chk("cnt1", 32'(s_count), 32'd1);
        step(1, 3, 2, 0, 0); chk("cnt2", 32'(s_count), 32'd2);
        step(1, 4, 2, 0, 0); chk("cnt3", 32'(s_count), 32'd3);
        step(0, 0, 0, 0, 0);
        chk("cnt4", 32'(s_count), 32'd4);
        chk("word_21234", 32'(s_data), 32'h21234);
        chk("load_pulse", 32'(s_load), 32'd1);
        step(0, 0, 0, 0, 0); chk("cnt_after_send", 32'(s_count), 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1); chk("no_fail_on_grant", 32'(s_fail), 32'd0);
        step(0, 0, 0, 0, 1); chk("logged_in", 32'(s_logged), 32'd1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        chk("logged_out", 32'(s_logged), 32'd0);
        chk("data_idle", 32'(s_data), 32'h0);

        // Three ungranted entries lead to lockout.
        fail_entry(la, fa);
        chk("fail1_load_at", 32'(la), 32'd0);
        chk("fail1_at", 32'(fa), 32'd8);
        fail_entry(la, fa);
        fail_entry(la, fa);
        chk("fail3_at", 32'(fa), 32'd8);
        nlock = 0; maxcnt = 0;
        for (int i = 0; i < LOCKC; i++) begin
            step(1, 7, 3, 0, 0);
            if (s_locked) nlock++;
            if (int'(s_count) > maxcnt) maxcnt = int'(s_count);
        end
        chk("lock_cycles", 32'(nlock), 32'd16);
        chk("digits_ignored", 32'(maxcnt), 32'd0);
        step(0, 0, 0, 0, 0); chk("unlocked", 32'(s_locked), 32'd0);
        enter(1, 9, 8, 7, 6);
        step(0, 0, 0, 0, 0); chk("word_19876", 32'(s_data), 32'h19876);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Abort on logout coincident with a third digit.
        step(1, 5, 1, 0, 0);
        step(1, 6, 1, 0, 0);
        step(1, 7, 1, 1, 0);
        nload = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 0) chk("abort_count", 32'(s_count), 32'd0);
            if (s_load) nload++;
        end
        chk("abort_no_load", 32'(nload), 32'd0);
        enter(3, 10, 11, 12, 13);
        step(0, 0, 0, 0, 0); chk("word_3abcd", 32'(s_data), 32'h3ABCD);

        // Grant exactly on the final wait cycle beats the timeout.
        for (int i = 0; i < GW - 1; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1); chk("late_grant_no_fail", 32'(s_fail), 32'd0);
        step(0, 0, 0, 0, 1); chk("late_grant_logged", 32'(s_logged), 32'd1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Reset mid-wait and mid-lockout clears the failure history.
        fail_entry(la, fa);
        enter(2, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        fail_entry(la, fa);
        fail_entry(la, fa);
        step(0, 0, 0, 0, 0); chk("two_fails_unlocked", 32'(s_locked), 32'd0);
        fail_entry(la, fa);
        step(0, 0, 0, 0, 0); chk("three_fails_locked", 32'(s_locked), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        do_reset();
        fail_entry(la, fa);
        fail_entry(la, fa);
        step(0, 0, 0, 0, 0); chk("relock_needs_three", 32'(s_locked), 32'd0);

        // Random traffic with a slowly toggling grant level.
        g = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) g = ~g;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 4, $urandom_range(0, 15), $urandom_range(0, 3),
                     $urandom_range(0, 24) == 0, g);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
